// File: rtl/posit_add_arb.sv
// posit_add: combinational posit adder, round-to-nearest-even, saturating at maxpos/minpos.
// Latency: none (pure combinational); start only qualifies the inf/zero flags.
// Backpressure: none; the caller registers inputs and outputs.
// Ports: in1/in2 operands, start qualifier; out sum, inf (either operand NaR), zero (both operands zero).
module posit_add #(
    parameter int N  = 32,
    parameter int es = 2
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         start,
    output logic [N-1:0] out,
    output logic         inf,
    output logic         zero
);
    localparam int MW = N - es;              // hidden one + widest fraction field
    localparam int SW = MW + N + 1;          // carry bit + mantissa + N guard bits
    localparam int TW = 2 + es + (SW - 1) + N;
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    // Magnitude decode into a signed scale (regime*2^es + exponent) and 1.f mantissa.
    function automatic void decode(input  logic [N-1:0]        x,
                                   output logic signed [31:0]  sc,
                                   output logic [MW-1:0]       m);
        logic [N-2:0] rem;
        logic [N-2:0] sh;
        logic         rb;
        logic         run_on;
        int           run;
        rem    = (N-1)'(x[N-1] ? -x : x);
        rb     = rem[N-2];
        run    = 0;
        run_on = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run_on && rem[i] == rb) run++;
            else run_on = 1'b0;
        end
        sh = rem << (run + 1);
        sc = (rb ? run - 1 : -run) * (2 ** es) + $signed(32'(sh[N-2 -: es]));
        m  = {1'b1, sh[N-2-es:0]};
    endfunction

    logic signed [31:0] sa, sb, sc_t, diff, sr, k;
    logic [MW-1:0]      ma, mb, mt;
    logic               sgn, sgn_b, sticky, inc;
    logic [SW-1:0]      xa, xb, xs, sum;
    logic [SW-2:0]      frac;
    logic [TW-1:0]      t;
    logic [N-2:0]       body;
    int                 lead, shamt;

    always_comb begin
        decode(in1, sa, ma);
        decode(in2, sb, mb);
        sgn   = in1[N-1];
        sgn_b = in2[N-1];
        sc_t  = sa;
        mt    = ma;
        // Keep the larger magnitude in the "a" slot so the difference is never negative.
        if (sb > sa || (sb == sa && mb > ma)) begin
            sa    = sb;
            ma    = mb;
            sb    = sc_t;
            mb    = mt;
            sgn   = in2[N-1];
            sgn_b = in1[N-1];
        end
        diff = sa - sb;
        xa   = {1'b0, ma, {N{1'b0}}};
        xb   = {1'b0, mb, {N{1'b0}}};
        if (diff >= SW) begin
            xs     = '0;
            sticky = 1'b1;
        end else begin
            xs     = xb >> diff;
            sticky = |(xb & ~({SW{1'b1}} << diff));
        end
        // Bits lost from b make the true difference slightly smaller: borrow one LSB.
        if (sgn == sgn_b) sum = xa + xs;
        else              sum = xa - xs - {{(SW-1){1'b0}}, sticky};
        lead = 0;
        for (int i = 0; i < SW; i++) if (sum[i]) lead = i;
        frac = (SW-1)'(sum << (SW - 1 - lead));
        sr   = sa + lead - (SW - 2);
        k    = sr >>> es;
        // Seed {rb, ~rb} then sign-extend by the run length to form the regime field.
        t     = {~k[31], k[31], sr[es-1:0], frac, {N{1'b0}}};
        shamt = k[31] ? ~k : k;
        t     = $signed(t) >>> shamt;
        body  = t[TW-1 -: N-1];
        inc   = t[TW-N] & (|t[TW-N-1:0] | sticky | body[0]) & ~&body;
        if (k > N - 2) begin
            body = '1;
            inc  = 1'b0;
        end else if (k < -(N - 2)) begin
            body = {{(N-2){1'b0}}, 1'b1};
            inc  = 1'b0;
        end
        body = body + {{(N-2){1'b0}}, inc};
        out  = sgn ? -{1'b0, body} : {1'b0, body};
        if (in1 == NAR || in2 == NAR) out = NAR;
        else if (in1 == '0)           out = in2;
        else if (in2 == '0)           out = in1;
        else if (sum == '0)           out = '0;
        inf  = start & ((in1 == NAR) || (in2 == NAR));
        zero = start & (in1 == '0) & (in2 == '0);
    end
endmodule

// posit_add_arb: round-robin sharing of one posit_add among NREQ requesters, ID-tagged results.
// Latency: gnt in cycle T gives done in cycle T+2; one result per cycle while out_ready is high.
// Backpressure: done && !out_ready freezes both stages; grants are withheld while stage 1 is full.
// Ports: clk, rst (sync, active-high); req/in1/in2 in, gnt out (combinational one-hot);
//        out/inf/zero/out_id/done out with out_ready in; busy = either stage holds a valid entry.
module posit_add_arb #(
    parameter int  N    = 32,
    parameter int  es   = 2,
    parameter int  NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] in1,
    input  logic [NREQ*N-1:0] in2,
    output logic [NREQ-1:0]   gnt,
    output logic [N-1:0]      out,
    output logic              inf,
    output logic              zero,
    output logic [IDW-1:0]    out_id,
    output logic              done,
    input  logic              out_ready,
    output logic              busy
);
    logic [IDW-1:0] ptr_q, ptr_d, id1_q, id1_d, out_id_q, out_id_d, w;
    logic [N-1:0]   in1_r_q, in1_r_d, in2_r_q, in2_r_d, out_q, out_d, sum_w;
    logic           v1_q, v1_d, done_q, done_d, inf_q, inf_d, zero_q, zero_d;
    logic           inf_w, zero_w, adv1, adv2, found;
    int             idx;

    posit_add #(.N(N), .es(es)) u_add (
        .in1   (in1_r_q),
        .in2   (in2_r_q),
        .start (v1_q),
        .out   (sum_w),
        .inf   (inf_w),
        .zero  (zero_w)
    );

    always_comb begin
        adv2  = !done_q || out_ready;
        adv1  = !v1_q || adv2;
        found = 1'b0;
        w     = '0;
        idx   = 0;
        // First requester at or after ptr, wrapping modulo NREQ.
        for (int j = 0; j < NREQ; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                w     = IDW'(idx);
            end
        end
        gnt = '0;
        if (adv1 && found && !rst) gnt[w] = 1'b1;

        ptr_d   = ptr_q;
        v1_d    = v1_q;
        id1_d   = id1_q;
        in1_r_d = in1_r_q;
        in2_r_d = in2_r_q;
        if (adv1) begin
            v1_d = found;
            if (found) begin
                in1_r_d = in1[int'(w)*N +: N];
                in2_r_d = in2[int'(w)*N +: N];
                id1_d   = w;
                ptr_d   = (int'(w) == NREQ - 1) ? '0 : w + IDW'(1);
            end
        end

        out_d    = out_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        out_id_d = out_id_q;
        done_d   = done_q;
        if (adv2) begin
            out_d    = sum_w;
            inf_d    = inf_w;
            zero_d   = zero_w;
            out_id_d = id1_q;
            done_d   = v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            v1_q     <= 1'b0;
            id1_q    <= '0;
            in1_r_q  <= '0;
            in2_r_q  <= '0;
            out_q    <= '0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            out_id_q <= '0;
            done_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            v1_q     <= v1_d;
            id1_q    <= id1_d;
            in1_r_q  <= in1_r_d;
            in2_r_q  <= in2_r_d;
            out_q    <= out_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            out_id_q <= out_id_d;
            done_q   <= done_d;
        end
    end

    assign out    = out_q;
    assign inf    = inf_q;
    assign zero   = zero_q;
    assign out_id = out_id_q;
    assign done   = done_q;
    assign busy   = v1_q | done_q;
endmodule

// File: tb/tb_posit_add_arb.sv
// tb_posit_add_arb: directed checks of arbitration, pipeline timing, stalls and posit sums.
// Latency: expects done two cycles after the grant when the result side is not stalled.
// Backpressure: holds out_ready low for a window and checks results freeze and none are lost.
module tb_posit_add_arb;
    logic         clk, rst, out_ready, inf, zero, done, busy;
    logic [3:0]   req, gnt, g_exp;
    logic [127:0] in1, in2;
    logic [31:0]  out;
    logic [1:0]   out_id;
    logic [36:0]  res_got, res_exp;
    int           vectors, miscompares;

    posit_add_arb #(.N(32), .es(2), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .in1(in1), .in2(in2), .gnt(gnt),
        .out(out), .inf(inf), .zero(zero), .out_id(out_id), .done(done),
        .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        in1[i*32 +: 32] = a;
        in2[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
        step(); #1;
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt);
        end
        step(); #1;
        res_got = {done, inf, zero, out_id, out};
        vectors++;
        if (res_got !== 37'd0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_state: got %h busy %b expected 0 busy 0", res_got, busy);
        end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_ops(0, 32'h40000000, 32'h40000000);
        req = 4'b0001; #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++; $display("FAIL single_gnt: got %b expected 0001", gnt);
        end
        step(); req = 4'b0000; #1;
        vectors++;
        if ({done, busy, gnt} !== 6'b010000) begin
            miscompares++; $display("FAIL single_t1: got %b expected 010000", {done, busy, gnt});
        end
        step(); #1;
        res_got = {done, inf, zero, out_id, out};
        res_exp = {3'b100, 2'd0, 32'h48000000};
        vectors++;
        if (res_got !== res_exp) begin
            miscompares++; $display("FAIL single_result: got %h expected %h", res_got, res_exp);
        end
        step(); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++; $display("FAIL single_drain: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 32'h40000000, 32'h48000000);
        for (int c = 0; c < 10; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000; #1;
            g_exp = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            vectors++;
            if (gnt !== g_exp) begin
                miscompares++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt, g_exp);
            end
            if (c >= 2) begin
                res_got = {done, inf, zero, out_id, out};
                res_exp = {3'b100, 2'((c - 2) % 4), 32'h4C000000};
                vectors++;
                if (res_got !== res_exp) begin
                    miscompares++; $display("FAIL rr_result c=%0d: got %h expected %h", c, res_got, res_exp);
                end
            end
            step();
        end
        #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++; $display("FAIL rr_drain: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ops(0, 32'h40000000, 32'h40000000);
        set_ops(1, 32'h40000000, 32'h48000000);
        set_ops(2, 32'h48000000, 32'h48000000);
        req = 4'b0011; #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++; $display("FAIL bp_gnt0: got %b expected 0001", gnt);
        end
        step(); req = 4'b0010; #1;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++; $display("FAIL bp_gnt1: got %b expected 0010", gnt);
        end
        step(); out_ready = 1'b0; req = 4'b0100;
        res_exp = {3'b100, 2'd0, 32'h48000000};
        for (int c = 0; c < 5; c++) begin
            #1;
            res_got = {done, inf, zero, out_id, out};
            vectors++;
            if (gnt !== 4'b0000 || busy !== 1'b1) begin
                miscompares++; $display("FAIL bp_stall_gnt c=%0d: got %b busy %b expected 0000 busy 1", c, gnt, busy);
            end
            vectors++;
            if (res_got !== res_exp) begin
                miscompares++; $display("FAIL bp_stall_hold c=%0d: got %h expected %h", c, res_got, res_exp);
            end
            step();
        end
        out_ready = 1'b1; #1;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++; $display("FAIL bp_release_gnt: got %b expected 0100", gnt);
        end
        step(); req = 4'b0000; #1;
        res_got = {done, inf, zero, out_id, out};
        res_exp = {3'b100, 2'd1, 32'h4C000000};
        vectors++;
        if (res_got !== res_exp) begin
            miscompares++; $display("FAIL bp_second: got %h expected %h", res_got, res_exp);
        end
        step(); #1;
        res_got = {done, inf, zero, out_id, out};
        res_exp = {3'b100, 2'd2, 32'h50000000};
        vectors++;
        if (res_got !== res_exp) begin
            miscompares++; $display("FAIL bp_third: got %h expected %h", res_got, res_exp);
        end
        step(); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++; $display("FAIL bp_drain: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_fairness();
        do_reset();
        set_ops(0, 32'h40000000, 32'h40000000);
        set_ops(1, 32'h40000000, 32'h48000000);
        for (int c = 0; c < 10; c++) begin
            req = (c < 8) ? 4'b0011 : 4'b0000; #1;
            g_exp = (c >= 8) ? 4'b0000 : ((c % 2 == 1) ? 4'b0010 : 4'b0001);
            vectors++;
            if (gnt !== g_exp) begin
                miscompares++; $display("FAIL fair_gnt c=%0d: got %b expected %b", c, gnt, g_exp);
            end
            if (c >= 2) begin
                res_got = {done, inf, zero, out_id, out};
                res_exp = ((c - 2) % 2 == 1) ? {3'b100, 2'd1, 32'h4C000000} : {3'b100, 2'd0, 32'h48000000};
                vectors++;
                if (res_got !== res_exp) begin
                    miscompares++; $display("FAIL fair_result c=%0d: got %h expected %h", c, res_got, res_exp);
                end
            end
            step();
        end
    endtask

    // Back-to-back grants to a single requester while walking special and rounding cases.
    task automatic test_back_to_back_special();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [33:0] ve [8];   // {inf, zero, out}
        va[0] = 32'h80000000; vb[0] = 32'h40000000; ve[0] = {2'b10, 32'h80000000};
        va[1] = 32'h00000000; vb[1] = 32'h00000000; ve[1] = {2'b01, 32'h00000000};
        va[2] = 32'h40000000; vb[2] = 32'hC0000000; ve[2] = {2'b00, 32'h00000000};
        va[3] = 32'h4C000000; vb[3] = 32'hC0000000; ve[3] = {2'b00, 32'h48000000};
        va[4] = 32'h7FFFFFFF; vb[4] = 32'h7FFFFFFF; ve[4] = {2'b00, 32'h7FFFFFFF};
        va[5] = 32'h40000000; vb[5] = 32'h00000000; ve[5] = {2'b00, 32'h40000000};
        va[6] = 32'h40000000; vb[6] = 32'h00000001; ve[6] = {2'b00, 32'h40000000};
        va[7] = 32'h40000000; vb[7] = 32'hFFFFFFFF; ve[7] = {2'b00, 32'h40000000};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                set_ops(0, va[c], vb[c]);
                req = 4'b0001;
            end else begin
                req = 4'b0000;
            end
            #1;
            if (c < 8) begin
                vectors++;
                if (gnt !== 4'b0001) begin
                    miscompares++; $display("FAIL b2b_gnt c=%0d: got %b expected 0001", c, gnt);
                end
            end
            if (c >= 2) begin
                res_got = {done, inf, zero, out_id, out};
                res_exp = {1'b1, ve[c-2][33:32], 2'd0, ve[c-2][31:0]};
                vectors++;
                if (res_got !== res_exp) begin
                    miscompares++; $display("FAIL special_%0d: got %h expected %h", c - 2, res_got, res_exp);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_ops(2, 32'h40000000, 32'h40000000);
        set_ops(3, 32'h40000000, 32'h48000000);
        req = 4'b0100; #1;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++; $display("FAIL mid_gnt: got %b expected 0100", gnt);
        end
        step(); rst = 1'b1; req = 4'b1000; #1;
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt);
        end
        step(); rst = 1'b0; req = 4'b0000; #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++; $display("FAIL mid_flush: got %b expected 00", {done, busy});
        end
        step(); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL mid_stale: got done %b expected 0", done);
        end
        req = 4'b1100; #1;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++; $display("FAIL mid_ptr: got %b expected 0100", gnt);
        end
        step(); req = 4'b0000;
        step(); #1;
        res_got = {done, inf, zero, out_id, out};
        res_exp = {3'b100, 2'd2, 32'h48000000};
        vectors++;
        if (res_got !== res_exp) begin
            miscompares++; $display("FAIL mid_result: got %h expected %h", res_got, res_exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; req = '0; out_ready = 1'b1; in1 = '0; in2 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_back_to_back_special();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/posit_add_arb.md
Name: posit_add_arb

Overview:
- Shares one combinational posit_add instance between NREQ requesters using round-robin arbitration.
- Two-stage pipeline: a registered operand stage feeds the adder, and a registered result stage drives the outputs.
- Each result carries a requester ID. A valid/ready handshake on the result side provides backpressure.
- Sits between vector/accumulator front-ends and the single posit adder in the arithmetic cluster.

Parameters:
- N, 32: posit width, passed to posit_add.
- es, 2: posit exponent size, passed to posit_add.
- NREQ, 4: number of requesters, 2..16.
- IDW, log2(NREQ) (minimum 1): width of the requester ID; derived, never overridden.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request. Once raised, it is held with operands stable until the matching gnt.
- in1  in  NREQ*N  operand A; requester i occupies bits [i*N +: N].
- in2  in  NREQ*N  operand B, same packing as in1.
- gnt  out  NREQ  one-hot grant, combinational. gnt[i] high in a cycle means in1/in2 slice i is captured at that cycle's closing edge.
- out  out  N  registered sum.
- inf  out  1  registered NaR flag from the adder.
- zero  out  1  registered both-zero flag from the adder.
- out_id  out  IDW  index of the requester that owns out.
- done  out  1  result valid.
- out_ready  in  1  consumer accepts the result when done and out_ready are both high.
- busy  out  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Reset (synchronous) clears:
  - v1 and v2 (stage valid bits);
  - the round-robin pointer ptr, to 0;
  - out, inf, zero, out_id and done, to 0.
- gnt is 0 whenever rst is high.
- Stage 1 holds in1_r, in2_r, id1 and v1. posit_add is fed from in1_r/in2_r with start tied to v1.
- Stage 2 holds out, inf, zero, out_id and done (done equals v2).
- Advance conditions:
  - adv2 = !done | out_ready
  - adv1 = !v1 | adv2
- Arbitration (combinational):
  - If adv1 is high, scan req starting at index ptr and wrapping modulo NREQ.
  - The first index found with req high is w; drive gnt[w] = 1.
  - If adv1 is low, gnt = 0.
- Grant edge: in1_r/in2_r take slice w, id1 <= w, v1 <= 1, ptr <= (w+1) mod NREQ.
- adv1 high with no request: v1 <= 0 and ptr holds.
- adv2 high: stage 2 loads the adder outputs out/inf/zero, out_id <= id1 and done <= v1.
- adv2 low: stage 2 and stage 1 hold. No overwrite ever occurs while done && !out_ready.
- Latency: gnt in cycle T gives done in cycle T+2 when unstalled.
- Throughput: one operation per cycle when out_ready is held high.
- Stall behaviour:
  - out, inf, zero and out_id stay stable while done && !out_ready.
  - At most 2 operations are in flight.
- A request arriving while adv1 is low waits; it is not dropped.
- Simultaneous requests: strict rotation. No requester waits more than NREQ-1 grants once its req is high.
- Only requester i with req[i] high can be granted; a single requester gets back-to-back grants.
- rst asserted mid-operation: in-flight entries are discarded and no done is produced for them. Requesters must re-request.
- NaR/zero handling is entirely posit_add's. The arbiter never alters out, inf or zero.

Test Plan:
- Single request: req=0001, slice0 in1=0x40000000, in2=0x40000000.
  -> gnt=0001 at T; at T+2 done=1, out=0x48000000, out_id=0, inf=0, zero=0.
- All four request every cycle with out_ready=1: slice i operands = 1.0 + 2.0 (0x40000000, 0x48000000).
  -> grants cycle 0,1,2,3,0..., done every cycle, out=0x4C000000, out_id sequence 0,1,2,3.
- Backpressure: two grants issued, then out_ready=0 for 5 cycles.
  -> gnt=0 during the stall, first result stable across all 5 cycles. After release, both results in order, one per cycle, none lost.
- Fairness with a persistent requester: req=0011 held.
  -> gnt alternates 0001/0010 every cycle; req0 never wins twice in a row.
- Special values:
  - NaR plus 1.0 (0x80000000, 0x40000000) -> inf=1, out=0x80000000.
  - 0 plus 0 -> zero=1, out=0.
- Reset mid-flight: rst=1 the cycle after a grant.
  -> next cycle done=0, busy=0, ptr=0. No stale result appears afterwards; the next grant goes to the lowest requesting index.
